// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_ctrl
// Description : Per-channel clock-gate controller. Each channel runs an
//               idle-timeout FSM (RUN/COUNT/GATED/WAKE) that drives the EN pin
//               of a clock-gate cell and an ACK handshake back to the consumer.
//               Optional gated-cycle statistics are compiled in when the macro
//               CLK_GATE_STAT_EN is defined; otherwise STAT_CNT is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int CH     = 4,
    parameter int IDLE_W = 4
) (
    input  logic                CK,
    input  logic                RST_B,
    input  logic                SE,
    input  logic [CH-1:0]       REQ,
    input  logic [IDLE_W-1:0]   IDLE_THR,
    input  logic                STAT_CLR,
    output logic [CH-1:0]       GATE_EN,
    output logic [CH-1:0]       ACK,
    output logic                ALL_GATED,
    output logic [16*CH-1:0]    STAT_CNT
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [IDLE_W-1:0] C_CNT_ONE = IDLE_W'(1);

    logic [CH-1:0] w_is_gated;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            state_t            r_state;
            state_t            w_state_nxt;
            logic [IDLE_W-1:0] r_cnt;
            logic [IDLE_W-1:0] w_cnt_nxt;
            logic              r_en;
            logic              r_ack;

            // State, idle counter and registered output decode of the current state
            always_ff @(posedge CK) begin
                if (!RST_B) begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_en    <= 1'b1;
                    r_ack   <= 1'b1;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_en    <= (r_state != ST_GATED);
                    r_ack   <= (r_state == ST_RUN) || (r_state == ST_COUNT);
                end
            end

            // Next-state logic; the threshold is captured only on RUN->COUNT
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    ST_RUN: begin
                        if (!REQ[i]) begin
                            if (IDLE_THR == '0) begin
                                w_state_nxt = ST_GATED;
                            end else begin
                                w_state_nxt = ST_COUNT;
                                w_cnt_nxt   = IDLE_THR;
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (REQ[i]) begin
                            w_state_nxt = ST_RUN;
                        end else if (r_cnt == C_CNT_ONE) begin
                            w_state_nxt = ST_GATED;
                        end else begin
                            w_cnt_nxt = r_cnt - C_CNT_ONE;
                        end
                    end
                    ST_GATED: begin
                        if (REQ[i]) begin
                            w_state_nxt = ST_WAKE;
                        end
                    end
                    default: begin
                        // WAKE always spends exactly one cycle before RUN
                        w_state_nxt = ST_RUN;
                    end
                endcase
            end

            assign GATE_EN[i]    = r_en | SE;
            assign ACK[i]        = r_ack;
            assign w_is_gated[i] = (r_state == ST_GATED);

`ifdef CLK_GATE_STAT_EN
            logic [15:0] r_stat;

            // Saturating count of cycles spent gated; clear wins over increment
            always_ff @(posedge CK) begin
                if (!RST_B) begin
                    r_stat <= '0;
                end else if (STAT_CLR) begin
                    r_stat <= '0;
                end else if ((r_state == ST_GATED) && (r_stat != 16'hFFFF)) begin
                    r_stat <= r_stat + 16'd1;
                end
            end

            assign STAT_CNT[16*i +: 16] = r_stat;
`else
            assign STAT_CNT[16*i +: 16] = 16'h0000;
`endif
        end
    endgenerate

`ifndef CLK_GATE_STAT_EN
    // Clear input has no effect when statistics are not built
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = STAT_CLR;
`endif

    assign ALL_GATED = &w_is_gated;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gate_ctrl
// Description : Self-checking bench for clk_gate_ctrl (CH=4, IDLE_W=4).
//               Directed scenarios followed by random traffic, all compared
//               against a cycle-level behavioural model of the gating rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int CH     = 4;
    localparam int IDLE_W = 4;

    logic              CK;
    logic              RST_B;
    logic              SE;
    logic [CH-1:0]     REQ;
    logic [IDLE_W-1:0] IDLE_THR;
    logic              STAT_CLR;
    logic [CH-1:0]     GATE_EN;
    logic [CH-1:0]     ACK;
    logic              ALL_GATED;
    logic [16*CH-1:0]  STAT_CNT;

    int checks = 0;
    int errors = 0;

    clk_gate_ctrl #(.CH(CH), .IDLE_W(IDLE_W)) u_dut (
        .CK       (CK),
        .RST_B    (RST_B),
        .SE       (SE),
        .REQ      (REQ),
        .IDLE_THR (IDLE_THR),
        .STAT_CLR (STAT_CLR),
        .GATE_EN  (GATE_EN),
        .ACK      (ACK),
        .ALL_GATED(ALL_GATED),
        .STAT_CNT (STAT_CNT)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // ---------------- behavioural model ----------------
    // gated    : channel clock is stopped
    // waking   : request seen while stopped, restart in progress
    // lows     : consecutive low request samples while running
    // thr_cap  : threshold captured at the first low sample
    bit          m_gated  [CH];
    bit          m_waking [CH];
    int          m_lows   [CH];
    int          m_thr    [CH];
    logic [CH-1:0] m_en;
    logic [CH-1:0] m_ack;
    int          m_stat   [CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_gated[c]  = 1'b0;
            m_waking[c] = 1'b0;
            m_lows[c]   = 0;
            m_thr[c]    = 0;
            m_stat[c]   = 0;
        end
        m_en  = '1;
        m_ack = '1;
    endtask

    task automatic model_edge();
        if (!RST_B) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            // outputs lag the channel condition by one edge
            m_en[c]  = !m_gated[c];
            m_ack[c] = !m_gated[c] && !m_waking[c];
`ifdef CLK_GATE_STAT_EN
            if (STAT_CLR)
                m_stat[c] = 0;
            else if (m_gated[c] && m_stat[c] < 65535)
                m_stat[c] = m_stat[c] + 1;
`endif
            if (m_gated[c]) begin
                if (REQ[c]) begin
                    m_gated[c]  = 1'b0;
                    m_waking[c] = 1'b1;
                end
            end else if (m_waking[c]) begin
                m_waking[c] = 1'b0;
                m_lows[c]   = 0;
            end else if (REQ[c]) begin
                m_lows[c] = 0;
            end else begin
                if (m_lows[c] == 0)
                    m_thr[c] = int'(IDLE_THR);
                m_lows[c] = m_lows[c] + 1;
                if (m_lows[c] > m_thr[c]) begin
                    m_gated[c] = 1'b1;
                    m_lows[c]  = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CH-1:0]    exp_en;
        logic [16*CH-1:0] exp_stat;
        logic             exp_all;
        exp_en  = m_en | {CH{SE}};
        exp_all = 1'b1;
        for (int c = 0; c < CH; c++) begin
            exp_all = exp_all & m_gated[c];
            exp_stat[16*c +: 16] = 16'(m_stat[c]);
        end
        chk("gate_en",   64'(GATE_EN),   64'(exp_en));
        chk("ack",       64'(ACK),       64'(m_ack));
        chk("all_gated", 64'(ALL_GATED), 64'(exp_all));
        chk("stat_cnt",  64'(STAT_CNT),  64'(exp_stat));
    endtask

    // one clock edge: model follows the sampled inputs, DUT checked 1 time unit later
    task automatic step();
        @(posedge CK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST_B    = 1'b0;
        SE       = 1'b0;
        REQ      = '1;
        IDLE_THR = 4'd3;
        STAT_CLR = 1'b0;
        model_reset();

        // reset state, with junk on ignored inputs
        REQ = 4'h0; STAT_CLR = 1'b1; IDLE_THR = 4'd0;
        steps(2);
        chk("reset_gate_en", 64'(GATE_EN), 64'hF);
        chk("reset_ack",     64'(ACK),     64'hF);
        chk("reset_all",     64'(ALL_GATED), 64'h0);
        chk("reset_stat",    64'(STAT_CNT),  64'h0);
        RST_B = 1'b1; REQ = 4'hF; STAT_CLR = 1'b0; IDLE_THR = 4'd3;
        steps(2);

        // channel 0 times out after IDLE_THR+1 edges; others untouched
        REQ[0] = 1'b0;
        step();                 // edge t
        IDLE_THR = 4'd9;        // ignored once counting
        steps(2);
        step();                 // edge t+3
        chk("thr3_en0_t3", 64'(GATE_EN[0]), 64'h1);
        step();                 // edge t+4
        chk("thr3_en0_t4",  64'(GATE_EN[0]), 64'h0);
        chk("thr3_ack0_t4", 64'(ACK[0]),     64'h0);
        chk("thr3_others",  64'(GATE_EN[3:1]), 64'h7);
        IDLE_THR = 4'd3;

        // short idle on channel 1 never gates
        REQ[1] = 1'b0;
        step(); chk("short_en1_a", 64'(GATE_EN[1]), 64'h1);
        step(); chk("short_en1_b", 64'(GATE_EN[1]), 64'h1);
        REQ[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("short_en1_c", 64'(GATE_EN[1]), 64'h1);
        end
        chk("short_ack1", 64'(ACK[1]), 64'h1);

        // zero threshold on channel 2, then wake
        IDLE_THR = 4'd0;
        REQ[2] = 1'b0;
        step();                 // edge t
        chk("thr0_en2_t", 64'(GATE_EN[2]), 64'h1);
        step();                 // edge t+1
        chk("thr0_en2_t1", 64'(GATE_EN[2]), 64'h0);
        steps(2);
        REQ[2] = 1'b1;
        step();                 // edge u
        chk("wake_en2_u", 64'(GATE_EN[2]), 64'h0);
        step();                 // edge u+1
        chk("wake_en2_u1",  64'(GATE_EN[2]), 64'h1);
        chk("wake_ack2_u1", 64'(ACK[2]),     64'h0);
        step();                 // edge u+2
        chk("wake_ack2_u2", 64'(ACK[2]), 64'h1);

        // wake with request already gone: must pass through RUN first
        REQ[0] = 1'b1; step(); REQ[0] = 1'b0; steps(4);

        // everything gated, then scan enable
        REQ = 4'h0;
        steps(20);
        chk("allg_flag", 64'(ALL_GATED), 64'h1);
        SE = 1'b1;
        step();
        chk("se_gate_en", 64'(GATE_EN), 64'hF);
        chk("se_ack",     64'(ACK),     64'h0);
        chk("se_all",     64'(ALL_GATED), 64'h1);
        SE = 1'b0;
        step();
        chk("se_off_gate_en", 64'(GATE_EN), 64'h0);

        // reset while channel 3 is counting
        REQ = 4'hF; IDLE_THR = 4'd3;
        steps(4);
        REQ[3] = 1'b0;
        steps(2);
        RST_B = 1'b0;
        step();
        chk("rst_mid_gate_en", 64'(GATE_EN),  64'hF);
        chk("rst_mid_ack",     64'(ACK),      64'hF);
        chk("rst_mid_stat",    64'(STAT_CNT), 64'h0);
        RST_B = 1'b1;
        step();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) REQ[c] = ~REQ[c];
            if ($urandom_range(0, 9) == 0) IDLE_THR = 4'($urandom_range(0, 6));
            SE       = ($urandom_range(0, 7) == 0);
            STAT_CLR = ($urandom_range(0, 29) == 0);
            RST_B    = ($urandom_range(0, 79) != 0);
            step();
        end
        RST_B = 1'b1; SE = 1'b0; STAT_CLR = 1'b0;

`ifdef CLK_GATE_STAT_EN
        // saturation and clear of channel 0 statistics
        REQ = 4'hF; IDLE_THR = 4'd0;
        steps(2);
        STAT_CLR = 1'b1; REQ[0] = 1'b0;
        step();
        STAT_CLR = 1'b0;
        steps(70000);
        chk("stat_sat", 64'(STAT_CNT[15:0]), 64'hFFFF);
        STAT_CLR = 1'b1;
        step();
        chk("stat_clr", 64'(STAT_CNT[15:0]), 64'h0);
        STAT_CLR = 1'b0;
        step();
`else
        // statistics absent: counts stay zero even with long gating
        REQ = 4'h0; IDLE_THR = 4'd0;
        steps(40);
        chk("stat_tied", 64'(STAT_CNT), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of independent gated-clock channels (1..16).
REQ-002 SHALL have parameter IDLE_W, default 4, meaning width of the idle-threshold field and the per-channel idle counter.
REQ-003 SHALL have port CK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_B  input  1  meaning reset; synchronous and active-low, sampled on the rising edge of CK.
REQ-005 SHALL have port SE  input  1  meaning scan/test enable, forcing all gate enables high.
REQ-006 SHALL have port REQ  input  CH  meaning per-channel clock request level from the consumer.
REQ-007 SHALL have port IDLE_THR  input  IDLE_W  meaning idle cycles to wait after a request drops before gating.
REQ-008 SHALL have port STAT_CLR  input  1  meaning synchronous clear of all gated-cycle statistics.
REQ-009 SHALL have port GATE_EN  output  CH  meaning per-channel enable driven to the EN pin of the clock-gate cell.
REQ-010 SHALL have port ACK  output  CH  meaning per-channel "gated clock is running and stable".
REQ-011 SHALL have port ALL_GATED  output  1  meaning every channel is in state GATED.
REQ-012 SHALL have port STAT_CNT  output  16*CH  meaning per-channel gated-cycle counts, channel i at bits [16*i+15:16*i].

Function
REQ-013 SHALL run one independent FSM per channel with states RUN, COUNT, GATED, WAKE.
REQ-014 SHALL decode outputs per state: RUN en=1 ack=1; COUNT en=1 ack=1; GATED en=0 ack=0; WAKE en=1 ack=0.
REQ-015 SHALL, in RUN with REQ[i]=0: go to GATED if IDLE_THR=0, else go to COUNT and load counter with IDLE_THR.
REQ-016 SHALL, in RUN with REQ[i]=1, remain in RUN.
REQ-017 SHALL, in COUNT with REQ[i]=1, return to RUN (counter discarded); with REQ[i]=0 and counter=1, go to GATED; otherwise decrement counter.
REQ-018 SHALL sample IDLE_THR only on RUN->COUNT entry; changes during COUNT are ignored.
REQ-019 SHALL deassert GATE_EN[i] exactly IDLE_THR+1 rising edges after the edge at which REQ[i] is first sampled low in RUN, provided REQ[i] stays low.
REQ-020 SHALL, in GATED with REQ[i]=1, go to WAKE; in WAKE go unconditionally to RUN (one cycle), giving ACK[i] rise 2 edges after REQ[i] sampled high.
REQ-021 SHALL, if REQ[i]=0 on entry to RUN from WAKE, proceed per REQ-015 on the next edge (no shortcut back to GATED).
REQ-022 SHALL register the per-state en/ack values; GATE_EN[i] = en_reg[i] | SE combinationally; ACK unaffected by SE.
REQ-023 SHALL leave FSMs running normally while SE=1.
REQ-024 SHALL drive ALL_GATED combinationally as AND over channels of (state==GATED).
REQ-025 SHALL treat channels fully independently; simultaneous events on different channels do not interact.

Reset
REQ-026 SHALL, on RST_B=0 at a CK edge, put every channel in RUN with counter 0: GATE_EN all 1, ACK all 1, ALL_GATED 0, STAT_CNT all 0.
REQ-027 SHALL let reset override any state mid-operation, including COUNT and WAKE, with no intermediate state.
REQ-028 SHALL ignore REQ, IDLE_THR and STAT_CLR while RST_B=0.

Configuration
REQ-029 SHALL compile gated-cycle statistics in only when macro CLK_GATE_STAT_EN is defined.
REQ-030 SHALL, with CLK_GATE_STAT_EN, increment STAT_CNT channel i each cycle the channel is in GATED, saturating at 0xFFFF; STAT_CLR=1 zeroes all counts, taking priority over increment.
REQ-031 SHALL, without CLK_GATE_STAT_EN, keep STAT_CNT port present, tied to 0, with STAT_CLR ignored and no counter flops.

Verification
REQ-032 SHALL cover: CH=4, IDLE_THR=3, REQ[0] 1->0 at edge t -> GATE_EN[0]=0 after edge t+4, ACK[0]=0 same edge, other channels unchanged.
REQ-033 SHALL cover: IDLE_THR=3, REQ[1] low for 2 cycles then high -> GATE_EN[1] never drops, state returns RUN.
REQ-034 SHALL cover: IDLE_THR=0, REQ[2] low at edge t -> GATE_EN[2]=0 after t+1; REQ[2] high at edge u -> GATE_EN[2]=1 after u+1, ACK[2]=1 after u+2.
REQ-035 SHALL cover: all channels GATED, SE=1 -> GATE_EN=4'hF, ACK=4'h0, ALL_GATED=1; SE=0 -> GATE_EN=4'h0.
REQ-036 SHALL cover: RST_B=0 for one edge while channel 3 in COUNT -> GATE_EN=4'hF, ACK=4'hF, STAT_CNT=0 next cycle.
REQ-037 SHALL cover with CLK_GATE_STAT_EN: channel 0 GATED 70000 cycles -> STAT_CNT[15:0]=0xFFFF; STAT_CLR pulse -> 0x0000 next cycle.
